riscv_run_ctrl: RTL and testbench
=================================

# riscv_run_ctrl

Host-side run controller for the RISC-V core, the counterpart to the core's memory-mapped stop register. It holds the core in reset, releases it on a host `start`, and waits for the core's "program finished" flag (`riscv_ready`). It measures run length in cycles, counts debug-flag toggles, and aborts on timeout. It sits in the fullchip core wrapper between the host/scan control interface and the core's active-low reset and status outputs.

## Interface
- `CNT_W`, 32: width of cycle counter and timeout value.
- `DBG_W`, 16: width of debug-toggle counter.
- `SYNC_STAGES`, 2: synchronizer flops on `riscv_ready_in` and `riscv_debug_in` (legal range 2–4).
- `clk` in 1: single clock; all logic on rising edge.
- `reset` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle run request.
- `abort` in 1: cancel a run in progress.
- `timeout_cycles` in CNT_W: run limit, sampled on accepted `start`; 0 disables timeout.
- `riscv_ready_in` in 1: core finished flag from the stop register.
- `riscv_debug_in` in 1: core debug toggle flag.
- `core_resetb` out 1: active-low reset to core; 0 = core held.
- `busy` out 1: high in RUN.
- `done` out 1: run ended by core ready; held until next start.
- `timed_out` out 1: run ended by timeout; held until next start.
- `cycle_count` out CNT_W: cycles spent in RUN, held after the run ends.
- `debug_toggles` out DBG_W: `riscv_debug_in` transitions seen in RUN, saturating.

## Operation
- States: IDLE, RUN, DONE, TMO.
- Reset: state IDLE, and all of the following are 0: `core_resetb`, `busy`, `done`, `timed_out`, `cycle_count`, `debug_toggles`, synchronizer flops and edge registers.
- `core_resetb` = 1 only in RUN. It is 0 in IDLE, DONE and TMO, so the core and stop register are reset between runs.
- Start handling:
  - IDLE/DONE/TMO + `start` → RUN.
  - On that edge: `cycle_count`←0, `debug_toggles`←0, `done`/`timed_out`←0, and `timeout_cycles` is latched internally.
  - `start` while in RUN is ignored.
- In RUN, checked each cycle in this priority order:
  1. `abort` → IDLE. Counters hold, `done`/`timed_out` stay 0.
  2. Synchronized-ready rising edge → DONE, `done`←1.
  3. Latched timeout nonzero and `cycle_count`+1 == timeout → TMO, `timed_out`←1.
  4. Otherwise stay in RUN.
- `cycle_count`:
  - Increments on every edge where state is RUN, including the exit edge.
  - Saturates at all-ones.
  - A run of N RUN cycles reads N in DONE.
- Ready detection:
  - Done is triggered only by a rising edge (0→1) of the synchronized ready, never by its level.
  - The edge register is not cleared on start. A ready still high from the previous run's flop pipeline therefore cannot complete a new run.
- Debug: each change of synchronized debug while in RUN increments `debug_toggles`, saturating at all-ones.
- Ready edge and timeout in the same cycle: DONE wins.
- `abort` outside RUN: no effect.
- `start` and `abort` together in IDLE: start wins.

## Timing
- `start` sampled high at edge N:
  - `busy`=1 and `core_resetb`=1 from edge N.
  - The core's first out-of-reset cycle begins after edge N.
- `riscv_ready_in` first sampled high at edge M (edge M–1 sampled low): `done`=1 and `core_resetb`=0 after edge M+SYNC_STAGES.
- Timeout T: exactly T cycles in RUN. TMO is entered at the edge where `cycle_count` becomes T.
- Outputs are all registered. There is no combinational path from input to output.
- `reset` overrides everything on the same edge, including mid-run: core goes back to reset and status clears.

## Structure
- Package `riscv_run_pkg`:
  - state enum `run_state_t` {IDLE, RUN, DONE, TMO};
  - localparams `DEF_CNT_W`=32, `DEF_DBG_W`=16, `DEF_SYNC_STAGES`=2.
- Sub-module `riscv_sync_edge`:
  - parameter `STAGES`;
  - ports `clk`, `reset`, `d`, `q`, `rise`, `change`;
  - instantiated once for ready and once for debug.
- Top holds the FSM, counters and timeout latch.

## Test plan
- Basic run: reset, `start`, `riscv_ready_in`↑ 100 cycles later → `done`=1 after 100+SYNC_STAGES edges, `cycle_count`=102, `core_resetb`=0, `busy`=0.
- Timeout: `timeout_cycles`=50, ready never rises → `timed_out`=1, `cycle_count`=50, `done`=0; ready rising afterwards → no change.
- Stale ready: ready held high across DONE→`start` for 5 cycles, then low, then high again at cycle 20 → stays in RUN until the second rise, then DONE.
- Debug: 3 toggles of `riscv_debug_in` (each ≥4 cycles apart) during RUN → `debug_toggles`=3; toggles in IDLE are not counted.
- Collisions: ready edge on the same cycle as timeout (`timeout_cycles` chosen to match) → DONE. `abort` in RUN → IDLE with `done`=`timed_out`=0. `start` during RUN → ignored.
- Reset mid-run: `reset` at cycle 30 of RUN → next edge: IDLE, all outputs 0; a subsequent `start` runs normally.

Source files
------------

// File: rtl/riscv_run_pkg.sv
// Shared types and default widths for the RISC-V host-side run controller.
package riscv_run_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2,
        TMO  = 2'd3
    } run_state_t;

    localparam int DEF_CNT_W       = 32;
    localparam int DEF_DBG_W       = 16;
    localparam int DEF_SYNC_STAGES = 2;

endpackage

// File: rtl/riscv_sync_edge.sv
// Multi-flop synchronizer with rise and change detection on the synchronized value.
module riscv_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q,
    output logic rise,
    output logic change
);

    logic [STAGES-1:0] r_sync;
    logic              r_prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], d};
            r_prev <= r_sync[STAGES-1];
        end
    end

    // r_prev is never cleared outside reset, so a level held high cannot re-trigger rise
    assign q      = r_sync[STAGES-1];
    assign rise   = r_sync[STAGES-1] & ~r_prev;
    assign change = r_sync[STAGES-1] ^ r_prev;

endmodule

// File: rtl/riscv_run_ctrl.sv
// Host-side run controller: holds the core in reset, runs it on start, and ends on ready, timeout or abort.
module riscv_run_ctrl
    import riscv_run_pkg::*;
#(
    parameter int CNT_W       = DEF_CNT_W,
    parameter int DBG_W       = DEF_DBG_W,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] timeout_cycles,
    input  logic             riscv_ready_in,
    input  logic             riscv_debug_in,
    output logic             core_resetb,
    output logic             busy,
    output logic             done,
    output logic             timed_out,
    output logic [CNT_W-1:0] cycle_count,
    output logic [DBG_W-1:0] debug_toggles
);

    run_state_t       r_state;
    run_state_t       w_state_nxt;
    logic [CNT_W-1:0] r_timeout;
    logic [CNT_W-1:0] r_cycle_count;
    logic [DBG_W-1:0] r_debug_toggles;
    logic             r_core_resetb;
    logic             r_busy;
    logic             r_done;
    logic             r_timed_out;

    logic             w_core_resetb_nxt;
    logic             w_busy_nxt;
    logic             w_done_nxt;
    logic             w_timed_out_nxt;

    logic             w_rdy_q;
    logic             w_rdy_rise;
    logic             w_rdy_change;
    logic             w_dbg_q;
    logic             w_dbg_rise;
    logic             w_dbg_change;
    logic             w_unused;

    logic [CNT_W:0]   w_cnt_plus1;
    logic             w_tmo_hit;
    logic             w_accept_start;

    riscv_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_ready (
        .clk    (clk),
        .reset  (reset),
        .d      (riscv_ready_in),
        .q      (w_rdy_q),
        .rise   (w_rdy_rise),
        .change (w_rdy_change)
    );

    riscv_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_debug (
        .clk    (clk),
        .reset  (reset),
        .d      (riscv_debug_in),
        .q      (w_dbg_q),
        .rise   (w_dbg_rise),
        .change (w_dbg_change)
    );

    assign w_unused = ^{w_rdy_q, w_rdy_change, w_dbg_q, w_dbg_rise};

    // One bit wider so the compare cannot wrap when the counter is saturated
    assign w_cnt_plus1    = {1'b0, r_cycle_count} + {{CNT_W{1'b0}}, 1'b1};
    assign w_tmo_hit      = (r_timeout != '0) && (w_cnt_plus1 == {1'b0, r_timeout});
    assign w_accept_start = (r_state != RUN) && start;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE, DONE, TMO: begin
                if (start) w_state_nxt = RUN;
            end
            RUN: begin
                if (abort)           w_state_nxt = IDLE;
                else if (w_rdy_rise) w_state_nxt = DONE;
                else if (w_tmo_hit)  w_state_nxt = TMO;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Status is decoded from the next state and registered, keeping outputs free of input paths
    always_comb begin
        w_core_resetb_nxt = (w_state_nxt == RUN);
        w_busy_nxt        = (w_state_nxt == RUN);
        w_done_nxt        = (w_state_nxt == DONE);
        w_timed_out_nxt   = (w_state_nxt == TMO);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_core_resetb <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_timed_out   <= 1'b0;
        end else begin
            r_core_resetb <= w_core_resetb_nxt;
            r_busy        <= w_busy_nxt;
            r_done        <= w_done_nxt;
            r_timed_out   <= w_timed_out_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cycle_count   <= '0;
            r_debug_toggles <= '0;
            r_timeout       <= '0;
        end else if (w_accept_start) begin
            r_cycle_count   <= '0;
            r_debug_toggles <= '0;
            r_timeout       <= timeout_cycles;
        end else if (r_state == RUN) begin
            if (r_cycle_count != '1) r_cycle_count <= r_cycle_count + 1'b1;
            if (w_dbg_change && (r_debug_toggles != '1)) r_debug_toggles <= r_debug_toggles + 1'b1;
        end
    end

    assign core_resetb   = r_core_resetb;
    assign busy          = r_busy;
    assign done          = r_done;
    assign timed_out     = r_timed_out;
    assign cycle_count   = r_cycle_count;
    assign debug_toggles = r_debug_toggles;

endmodule

// File: tb/tb_riscv_run_ctrl.sv
// Directed self-checking bench for riscv_run_ctrl with hand-computed expectations.
module tb_riscv_run_ctrl;

    logic        clk;
    logic        reset;
    logic        start;
    logic        abort;
    logic [31:0] timeout_cycles;
    logic        riscv_ready_in;
    logic        riscv_debug_in;
    logic        core_resetb;
    logic        busy;
    logic        done;
    logic        timed_out;
    logic [31:0] cycle_count;
    logic [15:0] debug_toggles;

    int tests_run;
    int tests_failed;

    riscv_run_ctrl #(.CNT_W(32), .DBG_W(16), .SYNC_STAGES(2)) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .abort          (abort),
        .timeout_cycles (timeout_cycles),
        .riscv_ready_in (riscv_ready_in),
        .riscv_debug_in (riscv_debug_in),
        .core_resetb    (core_resetb),
        .busy           (busy),
        .done           (done),
        .timed_out      (timed_out),
        .cycle_count    (cycle_count),
        .debug_toggles  (debug_toggles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_start(input logic [31:0] tmo);
        timeout_cycles = tmo;
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    // status vector order: {core_resetb, busy, done, timed_out}
    task automatic test_reset();
        reset = 1'b1;
        start = 1'b1;
        tick(2);
        start = 1'b0;
        tests_run++;
        if ({core_resetb, busy, done, timed_out} !== 4'b0000) begin
            tests_failed++;
            $display("FAIL reset_status: got %b expected 0000", {core_resetb, busy, done, timed_out});
        end
        tests_run++;
        if (cycle_count !== 32'd0 || debug_toggles !== 16'd0) begin
            tests_failed++;
            $display("FAIL reset_counters: got cnt=%0d dbg=%0d expected 0/0", cycle_count, debug_toggles);
        end
        reset = 1'b0;
        tick(2);
    endtask

    task automatic test_basic();
        do_start(32'd0);
        tests_run++;
        if ({core_resetb, busy, done, timed_out} !== 4'b1100 || cycle_count !== 32'd0) begin
            tests_failed++;
            $display("FAIL basic_start: got %b cnt=%0d expected 1100 cnt=0", {core_resetb, busy, done, timed_out}, cycle_count);
        end
        tick(99);
        riscv_ready_in = 1'b1;
        tick(2);
        tests_run++;
        if (done !== 1'b0 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL basic_early: got done=%b busy=%b expected 0/1", done, busy);
        end
        tick(1);
        tests_run++;
        if ({core_resetb, busy, done, timed_out} !== 4'b0010 || cycle_count !== 32'd102) begin
            tests_failed++;
            $display("FAIL basic_done: got %b cnt=%0d expected 0010 cnt=102", {core_resetb, busy, done, timed_out}, cycle_count);
        end
        tick(3);
        tests_run++;
        if (done !== 1'b1 || cycle_count !== 32'd102) begin
            tests_failed++;
            $display("FAIL basic_hold: got done=%b cnt=%0d expected 1 cnt=102", done, cycle_count);
        end
    endtask

    task automatic test_timeout();
        riscv_ready_in = 1'b0;
        tick(4);
        do_start(32'd50);
        tick(49);
        tests_run++;
        if (busy !== 1'b1 || timed_out !== 1'b0 || cycle_count !== 32'd49) begin
            tests_failed++;
            $display("FAIL tmo_before: got busy=%b tmo=%b cnt=%0d expected 1/0/49", busy, timed_out, cycle_count);
        end
        tick(1);
        tests_run++;
        if ({core_resetb, busy, done, timed_out} !== 4'b0001 || cycle_count !== 32'd50) begin
            tests_failed++;
            $display("FAIL tmo_hit: got %b cnt=%0d expected 0001 cnt=50", {core_resetb, busy, done, timed_out}, cycle_count);
        end
        riscv_ready_in = 1'b1;
        tick(5);
        tests_run++;
        if ({core_resetb, busy, done, timed_out} !== 4'b0001 || cycle_count !== 32'd50) begin
            tests_failed++;
            $display("FAIL tmo_late_ready: got %b cnt=%0d expected 0001 cnt=50", {core_resetb, busy, done, timed_out}, cycle_count);
        end
    endtask

    task automatic test_stale_ready();
        do_start(32'd0);
        tick(5);
        riscv_ready_in = 1'b0;
        tick(14);
        tests_run++;
        if (busy !== 1'b1 || done !== 1'b0 || cycle_count !== 32'd19) begin
            tests_failed++;
            $display("FAIL stale_hold: got busy=%b done=%b cnt=%0d expected 1/0/19", busy, done, cycle_count);
        end
        riscv_ready_in = 1'b1;
        tick(2);
        tests_run++;
        if (done !== 1'b0) begin
            tests_failed++;
            $display("FAIL stale_early: got done=%b expected 0", done);
        end
        tick(1);
        tests_run++;
        if ({core_resetb, busy, done, timed_out} !== 4'b0010 || cycle_count !== 32'd22) begin
            tests_failed++;
            $display("FAIL stale_done: got %b cnt=%0d expected 0010 cnt=22", {core_resetb, busy, done, timed_out}, cycle_count);
        end
    endtask

    task automatic test_debug_abort();
        riscv_ready_in = 1'b0;
        riscv_debug_in = 1'b1;
        tick(5);
        tests_run++;
        if (debug_toggles !== 16'd0) begin
            tests_failed++;
            $display("FAIL dbg_done_state: got %0d expected 0", debug_toggles);
        end
        do_start(32'd0);
        for (int k = 0; k < 3; k++) begin
            riscv_debug_in = ~riscv_debug_in;
            tick(5);
        end
        tick(5);
        tests_run++;
        if (debug_toggles !== 16'd3 || cycle_count !== 32'd20 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL dbg_run: got dbg=%0d cnt=%0d busy=%b expected 3/20/1", debug_toggles, cycle_count, busy);
        end
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        tests_run++;
        if ({core_resetb, busy, done, timed_out} !== 4'b0000 || cycle_count !== 32'd21) begin
            tests_failed++;
            $display("FAIL abort_idle: got %b cnt=%0d expected 0000 cnt=21", {core_resetb, busy, done, timed_out}, cycle_count);
        end
        riscv_debug_in = ~riscv_debug_in;
        abort = 1'b1;
        tick(5);
        abort = 1'b0;
        tests_run++;
        if (debug_toggles !== 16'd3 || cycle_count !== 32'd21 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL dbg_idle: got dbg=%0d cnt=%0d busy=%b expected 3/21/0", debug_toggles, cycle_count, busy);
        end
    endtask

    task automatic test_collision();
        do_start(32'd10);
        tick(7);
        riscv_ready_in = 1'b1;
        tick(2);
        tests_run++;
        if (busy !== 1'b1 || done !== 1'b0 || timed_out !== 1'b0) begin
            tests_failed++;
            $display("FAIL coll_before: got busy=%b done=%b tmo=%b expected 1/0/0", busy, done, timed_out);
        end
        tick(1);
        tests_run++;
        if ({core_resetb, busy, done, timed_out} !== 4'b0010 || cycle_count !== 32'd10) begin
            tests_failed++;
            $display("FAIL coll_done_wins: got %b cnt=%0d expected 0010 cnt=10", {core_resetb, busy, done, timed_out}, cycle_count);
        end
        riscv_ready_in = 1'b0;
        tick(4);
    endtask

    task automatic test_start_in_run();
        do_start(32'd0);
        tick(5);
        timeout_cycles = 32'd8;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tests_run++;
        if (busy !== 1'b1 || cycle_count !== 32'd6) begin
            tests_failed++;
            $display("FAIL restart_ignored: got busy=%b cnt=%0d expected 1/6", busy, cycle_count);
        end
        tick(4);
        tests_run++;
        if (busy !== 1'b1 || timed_out !== 1'b0 || cycle_count !== 32'd10) begin
            tests_failed++;
            $display("FAIL restart_no_tmo: got busy=%b tmo=%b cnt=%0d expected 1/0/10", busy, timed_out, cycle_count);
        end
        abort = 1'b1;
        tick(1);
        tests_run++;
        if (busy !== 1'b0 || cycle_count !== 32'd11) begin
            tests_failed++;
            $display("FAIL restart_abort: got busy=%b cnt=%0d expected 0/11", busy, cycle_count);
        end
        start = 1'b1;
        timeout_cycles = 32'd0;
        tick(1);
        start = 1'b0;
        abort = 1'b0;
        tests_run++;
        if ({core_resetb, busy, done, timed_out} !== 4'b1100 || cycle_count !== 32'd0) begin
            tests_failed++;
            $display("FAIL start_abort_idle: got %b cnt=%0d expected 1100 cnt=0", {core_resetb, busy, done, timed_out}, cycle_count);
        end
    endtask

    task automatic test_reset_mid_run();
        riscv_debug_in = ~riscv_debug_in;
        tick(30);
        tests_run++;
        if (busy !== 1'b1 || cycle_count !== 32'd30 || debug_toggles !== 16'd1) begin
            tests_failed++;
            $display("FAIL midrun_pre: got busy=%b cnt=%0d dbg=%0d expected 1/30/1", busy, cycle_count, debug_toggles);
        end
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        tests_run++;
        if ({core_resetb, busy, done, timed_out} !== 4'b0000 || cycle_count !== 32'd0 || debug_toggles !== 16'd0) begin
            tests_failed++;
            $display("FAIL midrun_reset: got %b cnt=%0d dbg=%0d expected 0000/0/0", {core_resetb, busy, done, timed_out}, cycle_count, debug_toggles);
        end
        tick(3);
        do_start(32'd0);
        tick(9);
        riscv_ready_in = 1'b1;
        tick(3);
        tests_run++;
        if ({core_resetb, busy, done, timed_out} !== 4'b0010 || cycle_count !== 32'd12) begin
            tests_failed++;
            $display("FAIL midrun_rerun: got %b cnt=%0d expected 0010 cnt=12", {core_resetb, busy, done, timed_out}, cycle_count);
        end
    endtask

    initial begin
        tests_run      = 0;
        tests_failed   = 0;
        reset          = 1'b1;
        start          = 1'b0;
        abort          = 1'b0;
        timeout_cycles = 32'd0;
        riscv_ready_in = 1'b0;
        riscv_debug_in = 1'b0;
        test_reset();
        test_basic();
        test_timeout();
        test_stale_ready();
        test_debug_abort();
        test_collision();
        test_start_in_run();
        test_reset_mid_run();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
